// File: rtl/iq_sigma_delta_dac.sv
// iq_sigma_delta_dac: dual-channel first-order sigma-delta DAC fed by an I/Q sample FIFO
// Ports: clk/reset (async, active-high); enable runs the modulator; rate_div sets the sample period minus 1;
// s_valid/s_ready/s_i/s_q push signed I/Q pairs; fifo_level is the occupancy; underrun is sticky, cleared by underrun_clr;
// cos_ds/cos_ds_n and sin_ds/sin_ds_n are the complementary pad bitstreams, all low while disabled.
// Optional: define DS_DITHER_EN to add LFSR carry-in dither to both accumulators.
module iq_sigma_delta_dac #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RATE_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [RATE_W-1:0]             rate_div,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_i,
  input  logic [DATA_W-1:0]             s_q,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic                          cos_ds,
  output logic                          cos_ds_n,
  output logic                          sin_ds,
  output logic                          sin_ds_n
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W-1:0] mem_i [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [RATE_W-1:0] cnt;
  logic [DATA_W-1:0] held_i, held_q, acc_i, acc_q;
  logic [DATA_W:0]   sum_i, sum_q;
  logic              strobe, empty, push, pop, cin_i, cin_q;
  assign fifo_level = level;
  assign empty      = level == '0;
  assign s_ready    = level != LW'(FIFO_DEPTH);
  assign strobe     = enable && cnt == '0;
  assign push       = s_valid && s_ready;
  assign pop        = strobe && !empty;
`ifdef DS_DITHER_EN
  logic [15:0] lfsr;
  // Fibonacci LFSR, taps 16,14,13,11, shifting right
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr <= 16'hACE1;
    else if (enable) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign cin_i = lfsr[0];
  assign cin_q = lfsr[1];
`else
  assign cin_i = 1'b0;
  assign cin_q = 1'b0;
`endif
  // Offset-binary conversion is just an MSB flip of the two's-complement sample
  assign sum_i = {1'b0, acc_i} + {1'b0, held_i ^ MSB} + {{DATA_W{1'b0}}, cin_i};
  assign sum_q = {1'b0, acc_q} + {1'b0, held_q ^ MSB} + {{DATA_W{1'b0}}, cin_q};
  always_ff @(posedge clk)
    if (push) begin
      mem_i[wr_ptr] <= s_i;
      mem_q[wr_ptr] <= s_q;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cnt      <= '0;
      held_i   <= '0;
      held_q   <= '0;
      acc_i    <= '0;
      acc_q    <= '0;
      underrun <= 1'b0;
      cos_ds   <= 1'b0;
      cos_ds_n <= 1'b0;
      sin_ds   <= 1'b0;
      sin_ds_n <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        held_i <= mem_i[rd_ptr];
        held_q <= mem_q[rd_ptr];
      end
      level    <= (push && !pop) ? level + LW'(1) : (pop && !push) ? level - LW'(1) : level;
      // Holding the reload value while disabled makes the first strobe land rate_div+1 cycles after enable
      cnt      <= (!enable || cnt == '0) ? rate_div : cnt - RATE_W'(1);
      underrun <= (strobe && empty) ? 1'b1 : underrun_clr ? 1'b0 : underrun;
      acc_i    <= enable ? sum_i[DATA_W-1:0] : '0;
      acc_q    <= enable ? sum_q[DATA_W-1:0] : '0;
      cos_ds   <= enable && sum_i[DATA_W];
      cos_ds_n <= enable && !sum_i[DATA_W];
      sin_ds   <= enable && sum_q[DATA_W];
      sin_ds_n <= enable && !sum_q[DATA_W];
    end
endmodule

// File: tb/tb_iq_sigma_delta_dac.sv
// tb_iq_sigma_delta_dac: self-checking bench for iq_sigma_delta_dac against a queue/integer reference model
module tb_iq_sigma_delta_dac;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] rate_div = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_i = '0;
  logic [7:0]  s_q = '0;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        underrun_clr = 1'b0;
  logic        cos_ds, cos_ds_n, sin_ds, sin_ds_n;
  int n_vec = 0;
  int n_err = 0;
  int q_i[$];
  int q_q[$];
  int m_hi, m_hq, m_ai, m_aq, m_cnt;
  bit m_und, m_ci, m_cn, m_si, m_sn;
  typedef struct {
    logic       sv;
    logic [7:0] i;
    logic [7:0] q;
    int         lvl;
    logic       rdy;
  } vec_t;
  vec_t tbl[5];
  iq_sigma_delta_dac dut (
    .clk(clk), .reset(reset), .enable(enable), .rate_div(rate_div),
    .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_clr(underrun_clr),
    .cos_ds(cos_ds), .cos_ds_n(cos_ds_n), .sin_ds(sin_ds), .sin_ds_n(sin_ds_n)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q_i.delete();
    q_q.delete();
    m_hi = 0; m_hq = 0; m_ai = 0; m_aq = 0; m_cnt = 0;
    m_und = 0; m_ci = 0; m_cn = 0; m_si = 0; m_sn = 0;
  endtask
  // Reference: pulse density by integer accumulation of the offset-binary sample
  task automatic model_step();
    bit strobe, push;
    int s;
    strobe = enable && m_cnt == 0;
    push   = s_valid && q_i.size() != 4;
    if (enable) begin
      s = m_ai + m_hi + 128; m_ci = s >= 256; m_cn = !m_ci; m_ai = s % 256;
      s = m_aq + m_hq + 128; m_si = s >= 256; m_sn = !m_si; m_aq = s % 256;
    end else begin
      m_ai = 0; m_aq = 0; m_ci = 0; m_cn = 0; m_si = 0; m_sn = 0;
    end
    m_und = (strobe && q_i.size() == 0) ? 1'b1 : underrun_clr ? 1'b0 : m_und;
    if (strobe && q_i.size() > 0) begin
      m_hi = q_i.pop_front();
      m_hq = q_q.pop_front();
    end
    if (push) begin
      q_i.push_back(int'($signed(s_i)));
      q_q.push_back(int'($signed(s_q)));
    end
    m_cnt = (!enable || m_cnt == 0) ? int'(rate_div) : m_cnt - 1;
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("s_ready", s_ready, q_i.size() != 4);
    chk("fifo_level", fifo_level, q_i.size());
    chk("underrun", underrun, m_und);
    chk("cos_ds", cos_ds, m_ci);
    chk("cos_ds_n", cos_ds_n, m_cn);
    chk("sin_ds", sin_ds, m_si);
    chk("sin_ds_n", sin_ds_n, m_sn);
  endtask
  task automatic run_to_strobe(output int n);
    bit s;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      s = enable && m_cnt == 0;
      step();
      n++;
      if (s) return;
    end
    chk("strobe_timeout", 0, 1);
  endtask
  initial begin
    int n, ones_c, ones_s;
    for (int k = 0; k < 5; k++) begin
      tbl[k].sv  = 1'b1;
      tbl[k].i   = 8'(8'h10 + k);
      tbl[k].q   = 8'(8'hF0 - k);
      tbl[k].lvl = (k < 4) ? k + 1 : 4;
      tbl[k].rdy = k < 3;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_ds", {cos_ds, cos_ds_n, sin_ds, sin_ds_n}, 0);
    reset = 1'b0;
    // mid-scale: I=Q=0 gives an alternating stream from acc=0
    rate_div = 16'd15;
    s_valid = 1'b1; s_i = 8'd0; s_q = 8'd0;
    step();
    s_valid = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("mid_cos", cos_ds, k % 2);
      chk("mid_cos_n", cos_ds_n, 1 - (k % 2));
      chk("mid_sin", sin_ds, k % 2);
    end
    // extremes: +127 on I, -128 on Q
    s_valid = 1'b1; s_i = 8'd127; s_q = 8'h80;
    step();
    s_valid = 1'b0;
    run_to_strobe(n);
    ones_c = 0; ones_s = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      ones_c += int'(cos_ds);
      ones_s += int'(sin_ds);
    end
    chk("ext_cos_ones", ones_c, 255);
    chk("ext_sin_ones", ones_s, 0);
    enable = 1'b0; underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("clr_underrun", underrun, 0);
    // FIFO fill with enable low, fifth pair rejected
    for (int k = 0; k < 5; k++) begin
      s_valid = tbl[k].sv; s_i = tbl[k].i; s_q = tbl[k].q;
      step();
      chk("tbl_level", fifo_level, tbl[k].lvl);
      chk("tbl_ready", s_ready, int'(tbl[k].rdy));
    end
    s_valid = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_to_strobe(n);
      chk("pop_gap", n, 16);
      chk("pop_level", fifo_level, 3 - k);
    end
    chk("pre_underrun", underrun, 0);
    run_to_strobe(n);
    chk("underrun_set", underrun, 1);
    for (int k = 0; k < 40 && m_cnt != 0; k++) step();
    underrun_clr = 1'b1;
    step();
    chk("underrun_set_wins", underrun, 1);
    step();
    underrun_clr = 1'b0;
    chk("underrun_clr", underrun, 0);
    // rate_div=0 with continuous valid: one push and one pop per cycle
    enable = 1'b0; rate_div = 16'd0;
    s_valid = 1'b1; s_i = 8'd40; s_q = 8'd200;
    step();
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      s_i = 8'($urandom); s_q = 8'($urandom);
      step();
      chk("pp_level", fifo_level, 1);
    end
    // reset with three entries queued, checked between clock edges
    s_valid = 1'b0; enable = 1'b0; rate_div = 16'd15;
    step();
    enable = 1'b1; s_valid = 1'b1; s_i = 8'd90; s_q = 8'd10;
    step();
    s_i = 8'd100;
    step();
    s_valid = 1'b0;
    chk("pre_rst_level", fifo_level, 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_level", fifo_level, 0);
    chk("arst_ready", s_ready, 1);
    chk("arst_ds", {cos_ds, cos_ds_n, sin_ds, sin_ds_n}, 0);
    chk("arst_underrun", underrun, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // randomized traffic against the reference model
    for (int k = 0; k < 1500; k++) begin
      enable       = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 7) == 0) rate_div = 16'($urandom_range(0, 6));
      s_valid      = $urandom_range(0, 1) == 1;
      s_i          = 8'($urandom);
      s_q          = 8'($urandom);
      underrun_clr = $urandom_range(0, 15) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
